alu_subtracter: RTL and testbench



---
 rtl/alu_subtracter_pkg.sv | 9 +
 rtl/alu_subtracter_full_subtractor.sv | 13 +
 rtl/alu_subtracter.sv | 81 ++++++++
 tb/tb_alu_subtracter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/alu_subtracter_pkg.sv
// Shared ALU package: default datapath width and the signed data type.
// Used by both the subtracter and the adder.
package alu_subtracter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/alu_subtracter_full_subtractor.sv
// One-bit full subtractor cell for the ripple-borrow chain.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/alu_subtracter.sv
// Registered two's-complement subtracter with zero/negative/overflow/borrow
// flags; captures on enable, holds otherwise.
module alu_subtracter
    import alu_subtracter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  negative,
    output logic                  overflow,
    output logic                  borrow
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH:0]   bchain;

    logic [DATA_WIDTH-1:0] result_d, result_q;
    logic                  zero_d, zero_q;
    logic                  negative_d, negative_q;
    logic                  overflow_d, overflow_q;
    logic                  borrow_d, borrow_q;

    assign bchain[0] = 1'b0;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chain
        full_subtractor u_fs (
            .a    (op1[i]),
            .b    (op2[i]),
            .bin  (bchain[i]),
            .d    (diff[i]),
            .bout (bchain[i+1])
        );
    end

    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        borrow_d   = borrow_q;
        if (enable) begin
            result_d   = diff;
            zero_d     = (diff == '0);
            negative_d = diff[MSB];
            // Operands of differing sign whose result flips away from op1
            overflow_d = (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]);
            borrow_d   = bchain[DATA_WIDTH];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            borrow_q   <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            borrow_q   <= borrow_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign negative = negative_q;
    assign overflow = overflow_q;
    assign borrow   = borrow_q;

endmodule

// File: tb/tb_alu_subtracter.sv
// Directed and sweep checks of alu_subtracter against a behavioural
// subtraction model through an expected-value queue.
module tb_alu_subtracter;
    import alu_subtracter_pkg::*;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [W-1:0] result;
    logic         zero, negative, overflow, borrow;

    int compared = 0;
    int mismatched = 0;

    // Packed as {result, zero, negative, overflow, borrow}
    logic [W+3:0] model_q = '0;
    logic [W+3:0] exp_q[$];

    alu_subtracter #(.DATA_WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .op1      (op1),
        .op2      (op2),
        .result   (result),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow),
        .borrow   (borrow)
    );

    always #5 clock = ~clock;

    function automatic logic [W+3:0] sub_model(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int signed    sa, sb, sd;
        logic [W-1:0] d;
        logic         v;
        sa = int'(data_t'(a));
        sb = int'(data_t'(b));
        sd = sa - sb;
        d  = W'(sd);
        v  = (sd > 32767) || (sd < -32768);
        return {d, d == '0, d[W-1], v, ({1'b0, a} < {1'b0, b})};
    endfunction

    function automatic logic [W+3:0] observed();
        return {result, zero, negative, overflow, borrow};
    endfunction

    task automatic check(input string tag, input logic [W+3:0] obs,
                         input logic [W+3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic en,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+3:0] e;
        op1 = a;
        op2 = b;
        enable = en;
        if (en) model_q = sub_model(a, b);
        exp_q.push_back(model_q);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check(tag, observed(), e);
    endtask

    initial begin
        #2;
        check("reset_state", observed(), '0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        step("pre_reset_0", 1'b1, 16'd5, 16'd3);
        step("pre_reset_1", 1'b1, 16'd5, 16'd3);
        check("pre_reset_val", observed(), {16'd2, 4'b0000});
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", observed(), '0);
        reset = 1'b0;
        model_q = '0;

        step("sub_5_3", 1'b1, 16'd5, 16'd3);
        check("sub_5_3_const", observed(), {16'd2, 4'b0000});
        step("sub_7_7", 1'b1, 16'd7, 16'd7);
        check("sub_7_7_const", observed(), {16'd0, 4'b1000});
        step("sub_0_1", 1'b1, 16'd0, 16'd1);
        check("sub_0_1_const", observed(), {16'hFFFF, 4'b0101});
        step("ovf_min_1", 1'b1, 16'h8000, 16'd1);
        check("ovf_min_1_const", observed(), {16'h7FFF, 4'b0010});
        step("ovf_max_m1", 1'b1, 16'h7FFF, 16'hFFFF);
        check("ovf_max_m1_const", observed(), {16'h8000, 4'b0111});

        step("hold_cap", 1'b1, 16'd9, 16'd4);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 16'd100, 16'd1);
        check("hold_const", observed(), {16'd5, 4'b0000});
        step("reenable", 1'b1, 16'd100, 16'd1);
        check("reenable_const", observed(), {16'd99, 4'b0000});

        for (int i = 0; i < 128; i++)
            step("sweep", 1'b1, W'(i % 16), W'(i / 16));

        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain: observed %0d left expected 0",
                     exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
